// File: rtl/waffle_solver_core.sv
// Streaming row/global min search over a row-major image in dual-read-port memory; row minima written at N+r.
// Optional WAFFLE_ARGMIN_EN: also tracks the lowest address of the global minimum and writes it to N+IMG_ROWS.
module waffle_solver_core #(
  parameter int IMG_ROWS = 32,
  parameter int IMG_COLS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data1,
  input  logic [31:0] in_data2,
  output logic [31:0] addr1,
  output logic [31:0] addr2,
  output logic [31:0] out_data1,
  output logic        we,
  output logic [31:0] result,
  output logic        complete
);

  localparam logic [31:0] NPIX      = 32'(IMG_ROWS * IMG_COLS);
  localparam logic [31:0] LAST_PAIR = 32'(IMG_COLS / 2 - 1);
  localparam logic [31:0] LAST_ROW  = 32'(IMG_ROWS - 1);

  typedef enum logic [1:0] {RD, WR, ARG, DONE} state_t;

  state_t      state_q;
  logic [31:0] row_q, pair_q;
  logic [31:0] addr1_q, addr2_q;
  logic        we_q;
  logic [31:0] run_q, glob_q;
  logic [31:0] result_q;
  logic        complete_q;

  logic        sel2, first_fold, row_take, glob_take;
  logic [31:0] pair_lo, fold_val, glob_val;

`ifdef WAFFLE_ARGMIN_EN
  logic [31:0] run_idx_q, glob_idx_q;
  logic [31:0] pair_idx, fold_idx, glob_idx_d;
`endif

  always_comb begin
    sel2       = in_data2 < in_data1;
    pair_lo    = sel2 ? in_data2 : in_data1;
    // The first pair of a row is taken unconditionally so an all-ones row still yields a valid index.
    first_fold = (state_q == RD) ? (pair_q == 32'd1) : (IMG_COLS == 2);
    row_take   = first_fold || (pair_lo < run_q);
    fold_val   = row_take ? pair_lo : run_q;
    glob_take  = (row_q == 32'd0) || (fold_val < glob_q);
    glob_val   = glob_take ? fold_val : glob_q;
`ifdef WAFFLE_ARGMIN_EN
    pair_idx   = ((state_q == WR) ? (addr2_q - 32'd1) : (addr1_q - 32'd2)) + {31'd0, sel2};
    fold_idx   = row_take ? pair_idx : run_idx_q;
    glob_idx_d = glob_take ? fold_idx : glob_idx_q;
`endif
    out_data1  = 32'd0;
    case (state_q)
      WR:      out_data1 = fold_val;
`ifdef WAFFLE_ARGMIN_EN
      ARG:     out_data1 = glob_idx_q;
`endif
      default: out_data1 = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RD;
      row_q      <= 32'd0;
      pair_q     <= 32'd0;
      addr1_q    <= 32'd0;
      addr2_q    <= 32'd1;
      we_q       <= 1'b0;
      run_q      <= '1;
      glob_q     <= '1;
      result_q   <= 32'd0;
      complete_q <= 1'b0;
`ifdef WAFFLE_ARGMIN_EN
      run_idx_q  <= 32'd0;
      glob_idx_q <= 32'd0;
`endif
    end else begin
      case (state_q)
        RD: begin
          if (pair_q != 32'd0) begin
            run_q <= fold_val;
`ifdef WAFFLE_ARGMIN_EN
            run_idx_q <= fold_idx;
`endif
          end
          if (pair_q == LAST_PAIR) begin
            state_q <= WR;
            addr1_q <= NPIX + row_q;
            we_q    <= 1'b1;
          end else begin
            pair_q  <= pair_q + 32'd1;
            addr1_q <= addr1_q + 32'd2;
            addr2_q <= addr2_q + 32'd2;
          end
        end
        WR: begin
          we_q   <= 1'b0;
          run_q  <= '1;
          glob_q <= glob_val;
`ifdef WAFFLE_ARGMIN_EN
          glob_idx_q <= glob_idx_d;
`endif
          if (row_q != LAST_ROW) begin
            // addr2 still holds the last pixel of this row, so the next row starts right after it.
            state_q <= RD;
            row_q   <= row_q + 32'd1;
            pair_q  <= 32'd0;
            addr1_q <= addr2_q + 32'd1;
            addr2_q <= addr2_q + 32'd2;
          end else begin
`ifdef WAFFLE_ARGMIN_EN
            state_q <= ARG;
            addr1_q <= NPIX + 32'(IMG_ROWS);
            we_q    <= 1'b1;
`else
            state_q    <= DONE;
            result_q   <= glob_val;
            complete_q <= 1'b1;
`endif
          end
        end
        ARG: begin
          we_q       <= 1'b0;
          state_q    <= DONE;
          result_q   <= glob_q;
          complete_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign addr1    = addr1_q;
  assign addr2    = addr2_q;
  assign we       = we_q;
  assign result   = result_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_waffle_solver_core.sv
// Scoreboard bench for waffle_solver_core: expected row-min writes queued per image, popped on each we pulse.
module tb_waffle_solver_core;

  localparam int R  = 32;
  localparam int C  = 32;
  localparam int N  = R * C;
  localparam int AW = $clog2(N);
`ifdef WAFFLE_ARGMIN_EN
  localparam int NWR = R + 1;
`else
  localparam int NWR = R;
`endif
  localparam int LAT = R * (C / 2 + 1) + (NWR - R);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data1 = 32'd0;
  logic [31:0] in_data2 = 32'd0;
  logic [31:0] addr1, addr2, out_data1, result;
  logic        we, complete;

  logic [31:0] img [0:N-1];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] exp_result;
  int          tests = 0;
  int          fails = 0;

  waffle_solver_core #(.IMG_ROWS(R), .IMG_COLS(C)) dut (
    .clk(clk), .rst(rst), .in_data1(in_data1), .in_data2(in_data2),
    .addr1(addr1), .addr2(addr2), .out_data1(out_data1), .we(we),
    .result(result), .complete(complete)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data1 <= (addr1 < 32'(N)) ? img[addr1[AW-1:0]] : 32'd0;
    in_data2 <= (addr2 < 32'(N)) ? img[addr2[AW-1:0]] : 32'd0;
  end

  task automatic load_img(input int pat);
    logic [31:0] m, gm, gi, v;
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       img[i] = 32'd7;
        1:       img[i] = 32'(1024 - i);
        2:       img[i] = (i == N - 1) ? 32'd0 : 32'hFFFF_FFFF;
        default: img[i] = (i == 5 || i == 600) ? 32'd3 : 32'd9;
      endcase
    end
    exp_q.delete();
    gm = '1;
    gi = 32'd0;
    for (int r = 0; r < R; r++) begin
      m = '1;
      for (int c = 0; c < C; c++) begin
        v = img[r * C + c];
        if (v < m) m = v;
        if (v < gm) begin
          gm = v;
          gi = 32'(r * C + c);
        end
      end
      exp_q.push_back('{a: 32'(N + r), d: m});
    end
    exp_result = gm;
`ifdef WAFFLE_ARGMIN_EN
    exp_q.push_back('{a: 32'(N + R), d: gi});
`endif
  endtask

  task automatic run_scan(input int pat, input string name);
    int          edges, wrs;
    logic [31:0] exp_rd;
    bit          done;
    wr_t         e;
    rst = 1'b0;
    load_img(pat);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    edges = 0;
    wrs   = 0;
    exp_rd = 32'd0;
    done  = 1'b0;
    while (!done) begin
      if (complete === 1'b1) begin
        done = 1'b1;
      end else if (we === 1'b1) begin
        wrs++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s extra_write addr1=%0d data=%h, no write expected", name, addr1, out_data1);
        end else begin
          e = exp_q.pop_front();
          if (addr1 !== e.a || out_data1 !== e.d) begin
            fails++;
            $display("FAIL %s write got addr=%0d data=%h expected addr=%0d data=%h",
                     name, addr1, out_data1, e.a, e.d);
          end
        end
      end else begin
        tests++;
        if (addr1 !== exp_rd || addr2 !== exp_rd + 32'd1 || we !== 1'b0) begin
          fails++;
          $display("FAIL %s rd_addr got addr1=%0d addr2=%0d we=%b expected %0d/%0d/0",
                   name, addr1, addr2, we, exp_rd, exp_rd + 32'd1);
        end
        exp_rd = exp_rd + 32'd2;
      end
      if (!done) begin
        if (edges >= LAT + 20) begin
          tests++;
          fails++;
          $display("FAIL %s timeout complete=%b after %0d cycles, required by %0d", name, complete, edges, LAT);
          done = 1'b1;
        end else begin
          @(posedge clk);
          edges++;
          @(negedge clk);
        end
      end
    end
    tests++;
    if (edges != LAT) begin
      fails++;
      $display("FAIL %s latency got %0d cycles expected %0d", name, edges, LAT);
    end
    tests++;
    if (result !== exp_result) begin
      fails++;
      $display("FAIL %s result got %h expected %h", name, result, exp_result);
    end
    tests++;
    if (wrs != NWR || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s write_count got %0d expected %0d (pending %0d)", name, wrs, NWR, exp_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (complete !== 1'b1 || we !== 1'b0 || result !== exp_result) begin
      fails++;
      $display("FAIL %s done_hold got complete=%b we=%b result=%h expected 1/0/%h",
               name, complete, we, result, exp_result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (addr1 !== 32'd0 || addr2 !== 32'd1) begin
      fails++;
      $display("FAIL reset_addr got addr1=%h addr2=%h expected 0/1", addr1, addr2);
    end
    tests++;
    if (we !== 1'b0 || out_data1 !== 32'd0) begin
      fails++;
      $display("FAIL reset_we got we=%b out_data1=%h expected 0/0", we, out_data1);
    end
    tests++;
    if (result !== 32'd0 || complete !== 1'b0) begin
      fails++;
      $display("FAIL reset_result got result=%h complete=%b expected 0/0", result, complete);
    end
  endtask

  task automatic test_uniform();
    run_scan(0, "uniform");
  endtask

  task automatic test_ramp();
    run_scan(1, "ramp");
  endtask

  task automatic test_last_pixel();
    run_scan(2, "last_pixel");
  endtask

  task automatic test_ties();
    run_scan(3, "ties");
  endtask

  task automatic test_mid_reset();
    int waited;
    rst = 1'b0;
    load_img(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    waited = 0;
    while (addr1 !== 32'(10 * C + 10) && waited < 1000) begin
      @(posedge clk);
      waited++;
      @(negedge clk);
    end
    tests++;
    if (waited >= 1000) begin
      fails++;
      $display("FAIL mid_reset_reach addr1=%0d never reached %0d", addr1, 10 * C + 10);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (addr1 !== 32'd0 || addr2 !== 32'd1 || we !== 1'b0 || out_data1 !== 32'd0 ||
        result !== 32'd0 || complete !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs got a1=%h a2=%h we=%b od=%h res=%h cmp=%b expected 0/1/0/0/0/0",
               addr1, addr2, we, out_data1, result, complete);
    end
    run_scan(3, "mid_reset_rerun");
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_ramp();
    test_last_pixel();
    test_ties();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/waffle_solver_core.md
Name: waffle_solver_core

Overview:
- Streaming min-search engine for a row-major image held in an external dual-read-port word memory (memory_export class).
- After reset it starts on its own and reads every pixel, two per cycle.
- It writes each row's minimum back to memory just after the image, reports the global minimum on result, then raises complete.
- Sits between the memory model and the top-level controller; the bench ends simulation on complete.

Parameters:
- IMG_ROWS, 32, number of image rows (≥1).
- IMG_COLS, 32, number of image columns (even, ≥2).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-low reset.
- in_data1  in  32  memory read data for addr1, valid one cycle after address issued.
- in_data2  in  32  memory read data for addr2, valid one cycle after address issued.
- addr1  out  32  read address port 1; also the write address when we=1.
- addr2  out  32  read address port 2 (read-only).
- out_data1  out  32  write data, qualified by we.
- we  out  1  write enable for addr1/out_data1.
- result  out  32  global minimum, valid when complete=1.
- complete  out  1  done flag, held until reset.

Behaviour:
- Pixels are unsigned 32-bit. Pixel (r,c) is at word address r*IMG_COLS+c. N = IMG_ROWS*IMG_COLS.
- Memory read latency is exactly 1 cycle. A write takes effect at the clock edge where we=1.
- Reset (rst=0 at posedge): state=RD, row=0, pair=0, running min=FFFF_FFFF, global min=FFFF_FFFF.
- Reset outputs: addr1=0, addr2=1, we=0, out_data1=0, result=0, complete=0.
- Reset asserted at any time aborts the operation and restarts from row 0 on release. No partial state survives.
- States are RD, WR and DONE.
- RD, row r, pair k (0..IMG_COLS/2-1):
  - Drive addr1=r*IMG_COLS+2k and addr2=addr1+1, we=0.
  - Fold the data returned this cycle (the previous cycle's pair) into the running row min. In the first RD cycle of a row, no pair is returned, so no fold.
  - After k=IMG_COLS/2-1, go to WR.
- WR (1 cycle per row):
  - Drive addr1=N+r, we=1, out_data1=min(running, in_data1, in_data2). This folds in the last pair combinationally.
  - addr2 holds its last value.
  - Global min ← min(global, out_data1). Running min ← FFFF_FFFF.
  - If r<IMG_ROWS-1: row++ and go to RD. Otherwise go to DONE.
- DONE:
  - result=global min and complete=1 from the first DONE cycle.
  - we=0; addresses frozen. Stay in DONE until reset.
- Ties: the minimum value is written; position is irrelevant.
- Total latency from reset release to complete=1: IMG_ROWS*(IMG_COLS/2+1) cycles, then complete on the next edge. Default size gives 544 cycles.
- Rows must not overlap the output region. The memory depth must be at least N+IMG_ROWS (+1 with the optional feature).

Optional Feature:
- WAFFLE_ARGMIN_EN defined:
  - The core tracks the word address of the first pixel (lowest address) holding the global minimum.
  - It spends one extra cycle after the last WR writing that index to address N+IMG_ROWS (we=1), then enters DONE.
  - Latency +1 cycle.
- WAFFLE_ARGMIN_EN undefined: no index tracking, no extra write. Behaviour is exactly as above.

Test Plan:
- 32x32 image all 7 → rows N..N+31 written 7, result=7, complete at cycle 545 after reset release.
- Descending ramp, pixel[i]=1024−i → row r min written as 1024−(32r+31), result=1.
- Single 0 at address 1023 (last pixel, port 2, combinational WR fold), rest 0xFFFF_FFFF → row 31 written 0, others 0xFFFF_FFFF, result=0. With WAFFLE_ARGMIN_EN, 1023 written at 1056.
- Ties: value 3 at addresses 5 and 600, rest 9 → result=3. With WAFFLE_ARGMIN_EN, index=5.
- Assert rst low mid-row 10, then release → outputs return to reset values, scan restarts at addr1=0/addr2=1, final results correct.
- Check we is high only in WR cycles (exactly 32 pulses) and addr2=addr1+1 in every RD cycle.
